mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mult_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and default sizing for the multiplier arbiter.
//   state_e     : arbiter FSM states
//   N_REQ_DEF   : default requester count
//   TIMEOUT_DEF : default completion wait bound, in cycles
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        in  N_REQ  request vector
//   last_grant in  IW     index granted last time
//   grant      out N_REQ  one-hot winner (zero when no request)
//   idx        out IW     winner index (0 when no request)
// The search starts at last_grant+1 and wraps, so the previous winner has
// the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_grant) + k) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among N_REQ requesters.
//   clock, reset_in             : clock, async active-low reset
//   req_valid/ready, operands   : per-requester request handshake
//   rsp_valid/ready, product,
//   overflow, timeout           : response to the granted requester
//   mul_* outputs / inputs      : shared multiplier port
//   busy_out                    : any state other than IDLE
// One operation at a time: IDLE -> ISSUE (start pulse) -> WAIT (done edge
// or timeout) -> RESPOND (hold until the granted requester takes it).
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clock,
  input  logic                   reset_in,
  input  logic [N_REQ-1:0]       req_valid_in,
  output logic [N_REQ-1:0]       req_ready_out,
  input  logic [N_REQ*WIDTH-1:0] req_multiplicand_in,
  input  logic [N_REQ*WIDTH-1:0] req_multiplier_in,
  output logic [N_REQ-1:0]       rsp_valid_out,
  input  logic [N_REQ-1:0]       rsp_ready_in,
  output logic [2*WIDTH-1:0]     rsp_product_out,
  output logic                   rsp_overflow_out,
  output logic                   rsp_timeout_out,
  output logic [WIDTH-1:0]       mul_multiplicand_out,
  output logic [WIDTH-1:0]       mul_multiplier_out,
  output logic                   mul_start_out,
  input  logic [2*WIDTH-1:0]     mul_product_in,
  input  logic                   mul_done_in,
  input  logic                   mul_overflow_in,
  output logic                   busy_out
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e             state, nstate;
  logic [IW-1:0]      last_grant, grant_idx, arb_idx;
  logic [N_REQ-1:0]   arb_grant;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [TW-1:0]      timer;
  logic               done_prev;
  logic [2*WIDTH-1:0] prod_q;
  logic               ovf_q, tmo_q;

  logic accept, done_edge, expired, rsp_take;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid_in),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .idx        (arb_idx)
  );

  // Ready is the arbiter winner, so any valid request in IDLE is a transfer.
  assign accept    = (state == S_IDLE) && (|req_valid_in);
  // done_prev tracks the level every cycle, so a level still high from an
  // earlier op (or on WAIT entry) never looks like a fresh completion.
  assign done_edge = mul_done_in & ~done_prev;
  assign expired   = (timer == T_LAST);
  assign rsp_take  = rsp_ready_in[grant_idx];

  // State register
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= nstate;
  end

  // Next-state logic; completion is checked before expiry so it wins a tie.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:    if (accept) nstate = S_ISSUE;
      S_ISSUE:   nstate = S_WAIT;
      S_WAIT:    if (done_edge || expired) nstate = S_RESPOND;
      S_RESPOND: if (rsp_take) nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_out = '0;
    rsp_valid_out = '0;
    mul_start_out = 1'b0;
    busy_out      = (state != S_IDLE);
    case (state)
      S_IDLE:    req_ready_out = arb_grant;
      S_ISSUE:   mul_start_out = 1'b1;
      S_RESPOND: rsp_valid_out[grant_idx] = 1'b1;
      default:   ;
    endcase
  end

  assign mul_multiplicand_out = mcand_q;
  assign mul_multiplier_out   = mplier_q;
  assign rsp_product_out      = prod_q;
  assign rsp_overflow_out     = ovf_q;
  assign rsp_timeout_out      = tmo_q;

  // Datapath: operands, grant bookkeeping, wait timer, captured result.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      last_grant <= IW'(N_REQ - 1);
      grant_idx  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      timer      <= '0;
      done_prev  <= 1'b0;
      prod_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      done_prev <= mul_done_in;
      case (state)
        S_IDLE: if (accept) begin
          mcand_q    <= req_multiplicand_in[arb_idx*WIDTH +: WIDTH];
          mplier_q   <= req_multiplier_in[arb_idx*WIDTH +: WIDTH];
          grant_idx  <= arb_idx;
          last_grant <= arb_idx;
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (done_edge) begin
            prod_q <= mul_product_in;
            ovf_q  <= mul_overflow_in;
            tmo_q  <= 1'b0;
          end else if (expired) begin
            prod_q <= '0;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset_in;
  logic [N-1:0]    req_valid_in, req_ready_out, rsp_valid_out, rsp_ready_in;
  logic [N*W-1:0]  req_multiplicand_in, req_multiplier_in;
  logic [2*W-1:0]  rsp_product_out, mul_product_in;
  logic            rsp_overflow_out, rsp_timeout_out;
  logic [W-1:0]    mul_multiplicand_out, mul_multiplier_out;
  logic            mul_start_out, mul_done_in, mul_overflow_in, busy_out;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  mult_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(64)) dut (
    .clock                (clock),
    .reset_in             (reset_in),
    .req_valid_in         (req_valid_in),
    .req_ready_out        (req_ready_out),
    .req_multiplicand_in  (req_multiplicand_in),
    .req_multiplier_in    (req_multiplier_in),
    .rsp_valid_out        (rsp_valid_out),
    .rsp_ready_in         (rsp_ready_in),
    .rsp_product_out      (rsp_product_out),
    .rsp_overflow_out     (rsp_overflow_out),
    .rsp_timeout_out      (rsp_timeout_out),
    .mul_multiplicand_out (mul_multiplicand_out),
    .mul_multiplier_out   (mul_multiplier_out),
    .mul_start_out        (mul_start_out),
    .mul_product_in       (mul_product_in),
    .mul_done_in          (mul_done_in),
    .mul_overflow_in      (mul_overflow_in),
    .busy_out             (busy_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, settle 1 time unit after it.
  task automatic tk();
    @(posedge clock);
    #1;
  endtask

  // Ready and response-valid must never have more than one bit set.
  always @(negedge clock) begin
    if (mon_on) begin
      chk("ready_onehot", 64'($countones(req_ready_out) <= 1), 64'd1);
      chk("rspv_onehot",  64'($countones(rsp_valid_out) <= 1), 64'd1);
    end
  end

  // Full handshake for one op with a done edge two cycles into WAIT.
  task automatic do_op(input string tag, input logic [N-1:0] exp_g, input logic [31:0] prod);
    #1;
    chk({tag, "_grant"}, 64'(req_ready_out), 64'(exp_g));
    tk();                                           // ISSUE
    chk({tag, "_start"}, 64'(mul_start_out), 64'd1);
    tk();                                           // WAIT
    chk({tag, "_start_lo"}, 64'(mul_start_out), 64'd0);
    chk({tag, "_noready"}, 64'(req_ready_out), 64'd0);
    tk();
    mul_done_in = 1'b1; mul_product_in = prod;
    tk();                                           // RESPOND
    mul_done_in = 1'b0;
    chk({tag, "_rspv"}, 64'(rsp_valid_out), 64'(exp_g));
    chk({tag, "_prod"}, 64'(rsp_product_out), 64'(prod));
    rsp_ready_in = exp_g;
    tk();                                           // IDLE
    rsp_ready_in = '0;
  endtask

  initial begin
    reset_in = 1'b0;
    req_valid_in = '0; rsp_ready_in = '0;
    req_multiplicand_in = {16'hAAAA, 16'h0007, 16'hBBBB, 16'hCCCC};
    req_multiplier_in   = {16'h1111, 16'hFFFD, 16'h2222, 16'h3333};
    mul_product_in = '0; mul_done_in = 1'b0; mul_overflow_in = 1'b0;
    #1;
    chk("rst_busy",  64'(busy_out), 64'd0);
    chk("rst_start", 64'(mul_start_out), 64'd0);
    chk("rst_rspv",  64'(rsp_valid_out), 64'd0);
    chk("rst_mcand", 64'(mul_multiplicand_out), 64'd0);
    chk("rst_prod",  64'(rsp_product_out), 64'd0);
    tk(); tk();
    reset_in = 1'b1;
    mon_on = 1'b1;

    // Requester 2: 7 x -3
    req_valid_in = 4'b0100;
    #1;
    chk("r2_ready", 64'(req_ready_out), 64'h4);
    chk("r2_idle_busy", 64'(busy_out), 64'd0);
    tk();                                           // ISSUE
    req_valid_in = '0;
    chk("r2_start", 64'(mul_start_out), 64'd1);
    chk("r2_busy", 64'(busy_out), 64'd1);
    chk("r2_mcand", 64'(mul_multiplicand_out), 64'h0007);
    chk("r2_mplier", 64'(mul_multiplier_out), 64'hFFFD);
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("r2_wait_start", 64'(mul_start_out), 64'd0);
      chk("r2_wait_rspv", 64'(rsp_valid_out), 64'd0);
    end
    mul_done_in = 1'b1; mul_product_in = 32'hFFFFFFEB;
    #1;
    chk("r2_done_cycle_rspv", 64'(rsp_valid_out), 64'd0);
    tk();                                           // RESPOND at D+1
    mul_done_in = 1'b0; mul_product_in = 32'h0;
    chk("r2_rspv", 64'(rsp_valid_out), 64'h4);
    chk("r2_prod", 64'(rsp_product_out), 64'hFFFFFFEB);
    chk("r2_tmo", 64'(rsp_timeout_out), 64'd0);
    chk("r2_hold_mcand", 64'(mul_multiplicand_out), 64'h0007);
    rsp_ready_in = 4'b1011;                         // non-granted bits ignored
    tk();
    chk("r2_ignore_rdy", 64'(rsp_valid_out), 64'h4);
    rsp_ready_in = 4'b0100;
    tk();
    rsp_ready_in = '0;
    chk("r2_back_idle", 64'(busy_out), 64'd0);

    // Fresh reset, all valid: rotation 0,1,2,3,0
    reset_in = 1'b0; #1; reset_in = 1'b1;
    req_valid_in = 4'b1111;
    do_op("rr0", 4'b0001, 32'h11);
    do_op("rr1", 4'b0010, 32'h22);
    do_op("rr2", 4'b0100, 32'h33);
    do_op("rr3", 4'b1000, 32'h44);
    do_op("rr4", 4'b0001, 32'h55);
    req_valid_in = '0;

    // Timeout on requester 1, then a 10-cycle response stall
    req_valid_in = 4'b0010;
    mul_product_in = 32'hDEADBEEF; mul_overflow_in = 1'b1;
    #1;
    chk("to_grant", 64'(req_ready_out), 64'h2);
    tk();                                           // ISSUE
    tk();                                           // WAIT, timer 0
    for (int i = 0; i < 64; i++) begin
      chk("to_wait_rspv", 64'(rsp_valid_out), 64'd0);
      tk();
    end
    chk("to_rspv", 64'(rsp_valid_out), 64'h2);
    chk("to_flag", 64'(rsp_timeout_out), 64'd1);
    chk("to_prod", 64'(rsp_product_out), 64'd0);
    chk("to_ovf", 64'(rsp_overflow_out), 64'd0);
    req_valid_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tk();
      chk("stall_rspv", 64'(rsp_valid_out), 64'h2);
      chk("stall_prod", 64'(rsp_product_out), 64'd0);
      chk("stall_tmo", 64'(rsp_timeout_out), 64'd1);
      chk("stall_ready", 64'(req_ready_out), 64'd0);
      chk("stall_busy", 64'(busy_out), 64'd1);
    end
    req_valid_in = '0;
    rsp_ready_in = 4'b0010;
    tk();
    rsp_ready_in = '0;
    chk("to_idle", 64'(busy_out), 64'd0);
    mul_overflow_in = 1'b0;

    // done left high: only a fresh rising edge completes
    mul_done_in = 1'b1; mul_product_in = 32'h12345678;
    req_valid_in = 4'b1000;
    #1;
    chk("lvl_grant", 64'(req_ready_out), 64'h8);
    tk();                                           // ISSUE
    req_valid_in = '0;
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("lvl_no_done", 64'(rsp_valid_out), 64'd0);
    end
    mul_done_in = 1'b0;
    tk();
    chk("lvl_low", 64'(rsp_valid_out), 64'd0);
    mul_done_in = 1'b1; mul_overflow_in = 1'b1;
    tk();
    mul_done_in = 1'b0; mul_overflow_in = 1'b0;
    chk("lvl_rspv", 64'(rsp_valid_out), 64'h8);
    chk("lvl_prod", 64'(rsp_product_out), 64'h12345678);
    chk("lvl_ovf", 64'(rsp_overflow_out), 64'd1);
    rsp_ready_in = 4'b1000;
    tk();
    rsp_ready_in = '0;

    // Reset pulse during WAIT
    req_valid_in = 4'b0100;
    #1;
    chk("mid_grant", 64'(req_ready_out), 64'h4);
    tk(); tk(); tk();                               // in WAIT
    req_valid_in = '0;
    #2;
    reset_in = 1'b0;
    #1;
    chk("mid_busy", 64'(busy_out), 64'd0);
    chk("mid_rspv", 64'(rsp_valid_out), 64'd0);
    chk("mid_mcand", 64'(mul_multiplicand_out), 64'd0);
    chk("mid_mplier", 64'(mul_multiplier_out), 64'd0);
    chk("mid_tmo", 64'(rsp_timeout_out), 64'd0);
    tk();
    reset_in = 1'b1;
    req_valid_in = 4'b1111;
    #1;
    chk("mid_next_grant", 64'(req_ready_out), 64'h1);
    req_valid_in = '0;
    mon_on = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
